// File: rtl/button_pulse_gen.sv
// Button debouncer with single-cycle press pulse and optional auto-repeat.
// Feeds the universal counter's count-enable from a raw board button.
module button_pulse_gen #(
    parameter int unsigned P_SAMPLE_PERIOD  = 2**16,
    parameter int unsigned P_STABLE_SAMPLES = 3,
    parameter int unsigned P_REPEAT_DELAY   = 32,
    parameter int unsigned P_REPEAT_RATE    = 8,
    parameter int unsigned P_ACTIVE_LOW     = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_IN,
    input  logic REPEAT_EN,
    output logic LEVEL,
    output logic PULSE
);

    localparam int unsigned PresW   = (P_SAMPLE_PERIOD > 2) ? $clog2(P_SAMPLE_PERIOD) : 1;
    localparam int unsigned HoldMax = (P_REPEAT_DELAY > P_REPEAT_RATE) ? P_REPEAT_DELAY
                                                                        : P_REPEAT_RATE;
    localparam int unsigned HoldW   = $clog2(HoldMax + 1);
    localparam int unsigned ShW     = P_STABLE_SAMPLES - 1;

    localparam logic             IdleLvl   = (P_ACTIVE_LOW != 0);
    localparam logic [PresW-1:0] PresLast  = PresW'(P_SAMPLE_PERIOD - 1);
    localparam logic [HoldW-1:0] HoldDelay = HoldW'(P_REPEAT_DELAY);
    localparam logic [HoldW-1:0] DelayM1   = HoldW'(P_REPEAT_DELAY - 1);
    localparam logic [HoldW-1:0] RateM1    = HoldW'(P_REPEAT_RATE - 1);

    typedef enum logic [1:0] {StIdle, StHeld, StRepeat} state_e;

    logic             sync1_q, sync2_q;
    logic             pressed_s;
    logic [PresW-1:0] pres_q;
    logic             tick;
    logic [ShW-1:0]   sh_q;
    logic             level_q;
    logic             all_ones, all_zeros, rise, fall;
    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             pulse_q, pulse_d;

    assign pressed_s = IdleLvl ? ~sync2_q : sync2_q;
    assign tick      = (pres_q == PresLast);
    // The current synchronized sample counts as the newest of the stable window.
    assign all_ones  = (&sh_q) & pressed_s;
    assign all_zeros = ~(|sh_q) & ~pressed_s;
    assign rise      = tick & all_ones & ~level_q;
    assign fall      = tick & all_zeros & level_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= IdleLvl;
            sync2_q <= IdleLvl;
            pres_q  <= '0;
            sh_q    <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= BTN_IN;
            sync2_q <= sync1_q;
            pres_q  <= tick ? '0 : pres_q + PresW'(1);
            if (tick) begin
                sh_q <= ShW'({sh_q, pressed_s});
            end
            if (rise) begin
                level_q <= 1'b1;
            end else if (fall) begin
                level_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            hold_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (tick) begin
            if (fall) begin
                state_d = StIdle;
                hold_d  = '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (rise) begin
                            state_d = StHeld;
                            hold_d  = '0;
                        end
                    end
                    StHeld: begin
                        if (REPEAT_EN && hold_q >= DelayM1) begin
                            state_d = StRepeat;
                            hold_d  = '0;
                        end else if (hold_q != HoldDelay) begin
                            hold_d = hold_q + HoldW'(1);
                        end
                    end
                    StRepeat: begin
                        if (!REPEAT_EN) begin
                            state_d = StHeld;
                            hold_d  = '0;
                        end else if (hold_q >= RateM1) begin
                            hold_d = '0;
                        end else begin
                            hold_d = hold_q + HoldW'(1);
                        end
                    end
                    default: begin
                        state_d = StIdle;
                        hold_d  = '0;
                    end
                endcase
            end
        end
    end

    // Release beats a coinciding repeat, so fall gates every pulse source.
    always_comb begin
        pulse_d = 1'b0;
        if (tick && !fall) begin
            unique case (state_q)
                StIdle:   pulse_d = rise;
                StHeld:   pulse_d = REPEAT_EN && (hold_q >= DelayM1);
                StRepeat: pulse_d = REPEAT_EN && (hold_q >= RateM1);
                default:  pulse_d = 1'b0;
            endcase
        end
    end

    assign LEVEL = level_q;
    assign PULSE = pulse_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen: cycle-exact press, bounce, repeat and reset scenarios.
module tb_button_pulse_gen;

    logic CLK;
    logic RST;
    logic BTN_IN;
    logic REPEAT_EN;
    logic LEVEL;
    logic PULSE;

    int checks    = 0;
    int errors    = 0;
    int c         = 0;
    int last_rise = -1;
    int last_fall = -1;
    int rise_cnt  = 0;
    bit lvl_prev  = 1'b0;
    int pulse_q[$];

    button_pulse_gen #(
        .P_SAMPLE_PERIOD (4),
        .P_STABLE_SAMPLES(3),
        .P_REPEAT_DELAY  (4),
        .P_REPEAT_RATE   (2),
        .P_ACTIVE_LOW    (1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN_IN   (BTN_IN),
        .REPEAT_EN(REPEAT_EN),
        .LEVEL    (LEVEL),
        .PULSE    (PULSE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; c numbers edges since the first reset release.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            c++;
            if (PULSE === 1'b1) pulse_q.push_back(c);
            if (LEVEL === 1'b1 && !lvl_prev) begin
                last_rise = c;
                rise_cnt++;
            end
            if (LEVEL !== 1'b1 && lvl_prev) last_fall = c;
            lvl_prev = (LEVEL === 1'b1);
        end
    endtask

    function automatic int pulses_in(input int a, input int b);
        int n = 0;
        foreach (pulse_q[i]) if (pulse_q[i] >= a && pulse_q[i] <= b) n++;
        return n;
    endfunction

    function automatic int first_pulse_from(input int a);
        foreach (pulse_q[i]) if (pulse_q[i] >= a) return pulse_q[i];
        return -1;
    endfunction

    initial begin
        RST       = 1'b1;
        BTN_IN    = 1'b1;
        REPEAT_EN = 1'b0;

        // Reset held 3 cycles with button idle
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check("rst_level", LEVEL, 0);
            check("rst_pulse", PULSE, 0);
        end
        RST = 1'b0;
        run(20);
        check("post_rst_pulses", pulses_in(1, 20), 0);
        check("post_rst_rises", rise_cnt, 0);

        // Clean press without repeat: one pulse at the third tick seeing pressed
        BTN_IN = 1'b0;
        run(40);
        check("press_pulses", pulses_in(21, 60), 1);
        check("press_pulse_cyc", first_pulse_from(21), 32);
        check("press_rise_cyc", last_rise, 32);
        check("press_level_held", LEVEL, 1);
        BTN_IN = 1'b1;
        run(20);
        check("release_pulses", pulses_in(61, 80), 0);
        check("release_fall_cyc", last_fall, 72);

        // Bounce: toggle every 3 cycles, then settle released
        for (int k = 0; k < 10; k++) begin
            BTN_IN = (k % 2 == 0) ? 1'b0 : 1'b1;
            run(3);
        end
        BTN_IN = 1'b1;
        run(20);
        check("bounce_pulses", pulses_in(81, 130), 0);
        check("bounce_rises", rise_cnt, 1);
        check("bounce_level", LEVEL, 0);

        // Auto-repeat: press at 144, first repeat 4 ticks later, then every 2 ticks
        REPEAT_EN = 1'b1;
        BTN_IN    = 1'b0;
        run(80);
        BTN_IN = 1'b1;
        run(30);
        check("rep_pulse_count", pulses_in(131, 240), 9);
        check("rep_press_cyc", first_pulse_from(131), 144);
        check("rep_first_cyc", first_pulse_from(145), 160);
        check("rep_second_cyc", first_pulse_from(161), 168);
        check("rep_after_release", pulses_in(217, 240), 0);
        check("rep_fall_cyc", last_fall, 224);

        // Repeat disable inside REPEAT, re-enable right after the HELD transition
        BTN_IN = 1'b0;
        run(46);
        REPEAT_EN = 1'b0;
        run(3);
        REPEAT_EN = 1'b1;
        run(17);
        BTN_IN = 1'b1;
        run(24);
        check("dis_pulses_before", pulses_in(241, 284), 4);
        check("dis_quiet_window", pulses_in(285, 303), 0);
        check("dis_reenable_cyc", first_pulse_from(285), 304);
        check("dis_release_prio", pulses_in(305, 330), 1);
        check("dis_fall_cyc", last_fall, 320);

        // Reset on the edge that would carry a repeat pulse
        BTN_IN = 1'b0;
        run(37);
        check("mid_pulses_before", pulses_in(331, 367), 2);
        RST = 1'b1;
        run(1);
        check("mid_rst_pulse", PULSE, 0);
        check("mid_rst_level", LEVEL, 0);
        RST = 1'b0;
        run(14);
        BTN_IN    = 1'b1;
        REPEAT_EN = 1'b0;
        run(28);
        check("mid_new_press_cyc", first_pulse_from(368), 380);
        check("mid_after_pulses", pulses_in(381, 410), 0);
        check("mid_fall_cyc", last_fall, 396);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
